// File: rtl/reg_scoreboard_if.sv
// ID-stage scoreboard bus: the instruction in ID, the WB retire port, and the
// hazard and status outputs. The master drives stimulus; the slave is the scoreboard.
interface reg_scoreboard_if #(
    parameter int STALL_CNT_W = 32
);
    logic                   id_valid;
    logic                   id_cancel;
    logic [4:0]             rs1_addr;
    logic                   rs1_use;
    logic [4:0]             rs2_addr;
    logic                   rs2_use;
    logic [4:0]             rd_addr;
    logic                   rd_we;
    logic                   exe_allow_in;
    logic                   wb_we;
    logic [4:0]             wb_addr;
    logic                   id_ready_go;
    logic                   issue;
    logic [31:0]            busy_vec;
    logic [STALL_CNT_W-1:0] stall_cycles;
    logic                   sb_error;

    modport master (
        output id_valid, id_cancel, rs1_addr, rs1_use, rs2_addr, rs2_use,
               rd_addr, rd_we, exe_allow_in, wb_we, wb_addr,
        input  id_ready_go, issue, busy_vec, stall_cycles, sb_error
    );

    modport slave (
        input  id_valid, id_cancel, rs1_addr, rs1_use, rs2_addr, rs2_use,
               rd_addr, rd_we, exe_allow_in, wb_we, wb_addr,
        output id_ready_go, issue, busy_vec, stall_cycles, sb_error
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for the ID stage. Each GPR has a counter of issued
// writes that have not yet retired. ID may hand off only when its sources are valid.
module reg_scoreboard #(
    parameter int CNT_W       = 2,
    parameter int WB_BYPASS   = 1,
    parameter int STALL_CNT_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    reg_scoreboard_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]       cnt_cur [32];
    logic [31:0]            busy;
    logic                   ret;
    logic                   inc;
    logic                   hazard1;
    logic                   hazard2;
    logic                   overflow;
    logic                   ready_go;
    logic                   issue_now;
    logic [STALL_CNT_W-1:0] stall_reg;
    logic                   sb_error_reg;

    assign cnt_cur[0] = '0;
    assign busy[0]    = 1'b0;

    assign ret = bus.wb_we & (bus.wb_addr != 5'd0);

    // A pending write whose last instance retires this cycle is readable when
    // the register file is write-first.
    always_comb begin
        hazard1 = bus.rs1_use & (bus.rs1_addr != 5'd0) & (cnt_cur[bus.rs1_addr] != '0);
        hazard2 = bus.rs2_use & (bus.rs2_addr != 5'd0) & (cnt_cur[bus.rs2_addr] != '0);
        if (WB_BYPASS != 0) begin
            if (ret && bus.wb_addr == bus.rs1_addr && cnt_cur[bus.rs1_addr] == CNT_ONE)
                hazard1 = 1'b0;
            if (ret && bus.wb_addr == bus.rs2_addr && cnt_cur[bus.rs2_addr] == CNT_ONE)
                hazard2 = 1'b0;
        end
    end

    assign overflow  = bus.rd_we & (bus.rd_addr != 5'd0) & (cnt_cur[bus.rd_addr] == CNT_MAX)
                     & ~(ret & (bus.wb_addr == bus.rd_addr));
    assign ready_go  = ~(hazard1 | hazard2 | overflow);
    assign issue_now = bus.id_valid & ready_go & bus.exe_allow_in & ~bus.id_cancel;
    assign inc       = issue_now & bus.rd_we & (bus.rd_addr != 5'd0);

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic             inc_hit;
            logic             ret_hit;

            assign inc_hit = inc & (bus.rd_addr == 5'(gi));
            assign ret_hit = ret & (bus.wb_addr == 5'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (inc_hit && !ret_hit) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end else if (ret_hit && !inc_hit && cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - CNT_ONE;
                end
            end

            assign cnt_cur[gi] = cnt_reg;
            assign busy[gi]    = (cnt_reg != '0);
        end
    endgenerate

    // A retire with nothing outstanding means the pipeline lost track of a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_reg    <= '0;
            sb_error_reg <= 1'b0;
        end else begin
            if (bus.id_valid && !ready_go && !bus.id_cancel)
                stall_reg <= stall_reg + STALL_CNT_W'(1);
            if (ret && cnt_cur[bus.wb_addr] == '0 && !(inc && bus.rd_addr == bus.wb_addr))
                sb_error_reg <= 1'b1;
        end
    end

    assign bus.id_ready_go  = ready_go;
    assign bus.issue        = issue_now;
    assign bus.busy_vec     = busy;
    assign bus.stall_cycles = stall_reg;
    assign bus.sb_error     = sb_error_reg;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard (CNT_W=2, WB_BYPASS=1): independent issue,
// RAW stall with bypass release, same-cycle inc/retire, overflow, r0/cancel, error and reset.
module tb_reg_scoreboard;
    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    reg_scoreboard_if #(.STALL_CNT_W(32)) bus ();

    reg_scoreboard #(
        .CNT_W      (2),
        .WB_BYPASS  (1),
        .STALL_CNT_W(32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid     = 1'b0;
        bus.id_cancel    = 1'b0;
        bus.rs1_addr     = 5'd0;
        bus.rs1_use      = 1'b0;
        bus.rs2_addr     = 5'd0;
        bus.rs2_use      = 1'b0;
        bus.rd_addr      = 5'd0;
        bus.rd_we        = 1'b0;
        bus.exe_allow_in = 1'b1;
        bus.wb_we        = 1'b0;
        bus.wb_addr      = 5'd0;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd,  input logic we);
        bus.id_valid = 1'b1;
        bus.rs1_addr = rs1;
        bus.rs1_use  = u1;
        bus.rs2_addr = rs2;
        bus.rs2_use  = u2;
        bus.rd_addr  = rd;
        bus.rd_we    = we;
    endtask

    task automatic retire(input logic [4:0] a);
        idle_inputs();
        bus.wb_we   = 1'b1;
        bus.wb_addr = a;
        step();
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        vec_cnt++; if (bus.busy_vec !== 32'h0) begin err_cnt++; $display("FAIL reset_busy: got %h want 0", bus.busy_vec); end
        vec_cnt++; if (bus.id_ready_go !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b want 1", bus.id_ready_go); end
        vec_cnt++; if (bus.issue !== 1'b0) begin err_cnt++; $display("FAIL reset_issue: got %b want 0", bus.issue); end
        vec_cnt++; if (bus.stall_cycles !== 32'd0) begin err_cnt++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cycles); end
        vec_cnt++; if (bus.sb_error !== 1'b0) begin err_cnt++; $display("FAIL reset_err: got %b want 0", bus.sb_error); end
        $display("test_reset done");
    endtask

    task automatic test_independent();
        set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1);
        #1;
        vec_cnt++; if (bus.issue !== 1'b1) begin err_cnt++; $display("FAIL indep_issue1: got %b want 1", bus.issue); end
        step();
        set_instr(5'd6, 1'b1, 5'd7, 1'b1, 5'd5, 1'b1);
        #1;
        vec_cnt++; if (bus.issue !== 1'b1) begin err_cnt++; $display("FAIL indep_issue2: got %b want 1", bus.issue); end
        vec_cnt++; if (bus.busy_vec !== 32'h10) begin err_cnt++; $display("FAIL indep_busy1: got %h want 10", bus.busy_vec); end
        step();
        idle_inputs();
        #1;
        vec_cnt++; if (bus.busy_vec !== 32'h30) begin err_cnt++; $display("FAIL indep_busy2: got %h want 30", bus.busy_vec); end
        vec_cnt++; if (bus.stall_cycles !== 32'd0) begin err_cnt++; $display("FAIL indep_stall: got %0d want 0", bus.stall_cycles); end
        retire(5'd4);
        retire(5'd5);
        vec_cnt++; if (bus.busy_vec !== 32'h0) begin err_cnt++; $display("FAIL indep_clean: got %h want 0", bus.busy_vec); end
        $display("test_independent done");
    endtask

    task automatic test_raw();
        set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1);
        #1;
        vec_cnt++; if (bus.issue !== 1'b1) begin err_cnt++; $display("FAIL raw_prod_issue: got %b want 1", bus.issue); end
        step();
        set_instr(5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            vec_cnt++; if (bus.id_ready_go !== 1'b0) begin err_cnt++; $display("FAIL raw_stall_%0d: got %b want 0", c, bus.id_ready_go); end
            step();
        end
        bus.wb_we   = 1'b1;
        bus.wb_addr = 5'd4;
        #1;
        vec_cnt++; if (bus.id_ready_go !== 1'b1) begin err_cnt++; $display("FAIL raw_wb_ready: got %b want 1", bus.id_ready_go); end
        vec_cnt++; if (bus.issue !== 1'b1) begin err_cnt++; $display("FAIL raw_wb_issue: got %b want 1", bus.issue); end
        step();
        idle_inputs();
        #1;
        vec_cnt++; if (bus.stall_cycles !== 32'd3) begin err_cnt++; $display("FAIL raw_stall_cnt: got %0d want 3", bus.stall_cycles); end
        vec_cnt++; if (bus.busy_vec !== 32'h100) begin err_cnt++; $display("FAIL raw_busy: got %h want 100", bus.busy_vec); end
        retire(5'd8);
        $display("test_raw done");
    endtask

    task automatic test_simultaneous();
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        step();
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        bus.wb_we   = 1'b1;
        bus.wb_addr = 5'd4;
        #1;
        vec_cnt++; if (bus.issue !== 1'b1) begin err_cnt++; $display("FAIL simul_issue: got %b want 1", bus.issue); end
        step();
        idle_inputs();
        #1;
        vec_cnt++; if (bus.busy_vec !== 32'h10) begin err_cnt++; $display("FAIL simul_busy: got %h want 10", bus.busy_vec); end
        retire(5'd4);
        vec_cnt++; if (bus.busy_vec !== 32'h0) begin err_cnt++; $display("FAIL simul_drain: got %h want 0", bus.busy_vec); end
        vec_cnt++; if (bus.sb_error !== 1'b0) begin err_cnt++; $display("FAIL simul_err: got %b want 0", bus.sb_error); end
        $display("test_simultaneous done");
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) begin
            set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
            #1;
            vec_cnt++; if (bus.issue !== 1'b1) begin err_cnt++; $display("FAIL ovf_issue_%0d: got %b want 1", k, bus.issue); end
            step();
        end
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        #1;
        vec_cnt++; if (bus.id_ready_go !== 1'b0) begin err_cnt++; $display("FAIL ovf_ready: got %b want 0", bus.id_ready_go); end
        vec_cnt++; if (bus.issue !== 1'b0) begin err_cnt++; $display("FAIL ovf_noissue: got %b want 0", bus.issue); end
        step();
        bus.wb_we   = 1'b1;
        bus.wb_addr = 5'd9;
        #1;
        vec_cnt++; if (bus.issue !== 1'b1) begin err_cnt++; $display("FAIL ovf_wb_issue: got %b want 1", bus.issue); end
        step();
        idle_inputs();
        #1;
        vec_cnt++; if (bus.busy_vec !== 32'h200) begin err_cnt++; $display("FAIL ovf_busy: got %h want 200", bus.busy_vec); end
        vec_cnt++; if (bus.stall_cycles !== 32'd4) begin err_cnt++; $display("FAIL ovf_stall: got %0d want 4", bus.stall_cycles); end
        retire(5'd9);
        retire(5'd9);
        vec_cnt++; if (bus.busy_vec !== 32'h200) begin err_cnt++; $display("FAIL ovf_partial: got %h want 200", bus.busy_vec); end
        retire(5'd9);
        vec_cnt++; if (bus.busy_vec !== 32'h0) begin err_cnt++; $display("FAIL ovf_drain: got %h want 0", bus.busy_vec); end
        vec_cnt++; if (bus.sb_error !== 1'b0) begin err_cnt++; $display("FAIL ovf_err: got %b want 0", bus.sb_error); end
        $display("test_overflow done");
    endtask

    task automatic test_r0_cancel();
        set_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        vec_cnt++; if (bus.issue !== 1'b1) begin err_cnt++; $display("FAIL r0_issue: got %b want 1", bus.issue); end
        step();
        idle_inputs();
        #1;
        vec_cnt++; if (bus.busy_vec !== 32'h0) begin err_cnt++; $display("FAIL r0_busy: got %h want 0", bus.busy_vec); end
        set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
        bus.id_cancel = 1'b1;
        #1;
        vec_cnt++; if (bus.issue !== 1'b0) begin err_cnt++; $display("FAIL cancel_issue: got %b want 0", bus.issue); end
        step();
        idle_inputs();
        #1;
        vec_cnt++; if (bus.busy_vec !== 32'h0) begin err_cnt++; $display("FAIL cancel_busy: got %h want 0", bus.busy_vec); end
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        step();
        set_instr(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        bus.id_cancel = 1'b1;
        #1;
        vec_cnt++; if (bus.id_ready_go !== 1'b0) begin err_cnt++; $display("FAIL cancel_hazard: got %b want 0", bus.id_ready_go); end
        step();
        idle_inputs();
        #1;
        vec_cnt++; if (bus.stall_cycles !== 32'd4) begin err_cnt++; $display("FAIL cancel_stall: got %0d want 4", bus.stall_cycles); end
        retire(5'd4);
        $display("test_r0_cancel done");
    endtask

    task automatic test_error_reset();
        retire(5'd7);
        vec_cnt++; if (bus.sb_error !== 1'b1) begin err_cnt++; $display("FAIL err_set: got %b want 1", bus.sb_error); end
        set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        step();
        set_instr(5'd4, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
        step();
        vec_cnt++; if (bus.stall_cycles !== 32'd5) begin err_cnt++; $display("FAIL err_stall: got %0d want 5", bus.stall_cycles); end
        reset       = 1'b1;
        bus.wb_we   = 1'b1;
        bus.wb_addr = 5'd4;
        step();
        vec_cnt++; if (bus.busy_vec !== 32'h0) begin err_cnt++; $display("FAIL rst_busy: got %h want 0", bus.busy_vec); end
        vec_cnt++; if (bus.stall_cycles !== 32'd0) begin err_cnt++; $display("FAIL rst_stall: got %0d want 0", bus.stall_cycles); end
        vec_cnt++; if (bus.sb_error !== 1'b0) begin err_cnt++; $display("FAIL rst_err: got %b want 0", bus.sb_error); end
        reset = 1'b0;
        idle_inputs();
        step();
        vec_cnt++; if (bus.sb_error !== 1'b0) begin err_cnt++; $display("FAIL rst_wb_ignored: got %b want 0", bus.sb_error); end
        vec_cnt++; if (bus.id_ready_go !== 1'b1) begin err_cnt++; $display("FAIL rst_ready: got %b want 1", bus.id_ready_go); end
        $display("test_error_reset done");
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        reset   = 1'b1;
        idle_inputs();
        test_reset();
        test_independent();
        test_raw();
        test_simultaneous();
        test_overflow();
        test_r0_cancel();
        test_error_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end
endmodule
